pci_parity_checker: RTL and testbench



---
 rtl/pci_pkg.sv | 20 ++
 rtl/pci_parity_calc.sv | 8 +
 rtl/pci_parity_checker.sv | 74 +++++++
 tb/tb_pci_parity_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// pci_pkg: PCI command codes, config register bit indices and parity-check tags
package pci_pkg;
    localparam logic [3:0] CMD_INT_ACK     = 4'b0000;
    localparam logic [3:0] CMD_SPECIAL     = 4'b0001;
    localparam logic [3:0] CMD_IO_RD       = 4'b0010;
    localparam logic [3:0] CMD_IO_WR       = 4'b0011;
    localparam logic [3:0] CMD_MEM_RD      = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR      = 4'b0111;
    localparam logic [3:0] CMD_CFG_RD      = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR      = 4'b1011;
    localparam logic [3:0] CMD_MEM_RD_MULT = 4'b1100;
    localparam logic [3:0] CMD_DAC         = 4'b1101;
    localparam logic [3:0] CMD_MEM_RD_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WR_INV  = 4'b1111;
    localparam int STS_DPE     = 15;
    localparam int STS_SSE     = 14;
    localparam int CMD_PERR_EN = 6;
    localparam int CMD_SERR_EN = 8;
    typedef enum logic [1:0] {TAG_NONE, TAG_ADDR, TAG_DATA} tag_e;
endpackage

// File: rtl/pci_parity_calc.sv
// pci_parity_calc: even parity over AD and C/BE#, shared with the transmit-side generator
module pci_parity_calc (
    input  logic [31:0] ad,
    input  logic [3:0]  cben,
    output logic        par
);
    assign par = ^{ad, cben};
endmodule

// File: rtl/pci_parity_checker.sv
// pci_parity_checker: receive-side PCI parity check driving PERR#/SERR#, status bits and error count
module pci_parity_checker
    import pci_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             PHY_CLK33_I,
    input  logic             PHY_RSTn_I,
    input  logic [31:0]      PGEN_AD_I,
    input  logic [3:0]       PGEN_CBEn_I,
    input  logic             PGEN_PAR_I,
    input  logic             FRAMEn_I,
    input  logic             IRDYn_I,
    input  logic             TRDYn_I,
    input  logic             TGT_WR_I,
    input  logic             PERR_EN_I,
    input  logic             SERR_EN_I,
    input  logic             STS_CLR_I,
    output logic             PERRn_O,
    output logic             PERR_OE_O,
    output logic             SERRn_O,
    output logic             SERR_OE_O,
    output logic             DPE_STS_O,
    output logic             SSE_STS_O,
    output logic [CNT_W-1:0] PERR_CNT_O
);
    logic calc, calc_q, frame_q, dac_q, addr_err_q, data_err_q, perr_hi_q;
    logic mismatch, perr_drive, err;
    tag_e tag, tag_q;
    pci_parity_calc u_calc (
        .ad   (PGEN_AD_I),
        .cben (PGEN_CBEn_I),
        .par  (calc)
    );
    // the second DAC address cycle carries the upper address with its own parity, left unchecked
    always_comb begin
        tag = dac_q ? TAG_NONE :
              (!FRAMEn_I && frame_q) ? TAG_ADDR :
              (!IRDYn_I && !TRDYn_I && TGT_WR_I) ? TAG_DATA : TAG_NONE;
        mismatch = PGEN_PAR_I != calc_q;
        perr_drive = data_err_q && PERR_EN_I;
        err = addr_err_q || data_err_q;
    end
    assign PERRn_O   = !perr_drive;
    assign PERR_OE_O = perr_drive || perr_hi_q;
    assign SERR_OE_O = addr_err_q && PERR_EN_I && SERR_EN_I;
    assign SERRn_O   = !SERR_OE_O;
    always_ff @(posedge PHY_CLK33_I) begin
        if (!PHY_RSTn_I) begin
            frame_q    <= 1'b1;
            dac_q      <= 1'b0;
            calc_q     <= 1'b0;
            tag_q      <= TAG_NONE;
            addr_err_q <= 1'b0;
            data_err_q <= 1'b0;
            perr_hi_q  <= 1'b0;
            DPE_STS_O  <= 1'b0;
            SSE_STS_O  <= 1'b0;
            PERR_CNT_O <= '0;
        end else begin
            frame_q    <= FRAMEn_I;
            dac_q      <= tag == TAG_ADDR && PGEN_CBEn_I == CMD_DAC;
            calc_q     <= calc;
            tag_q      <= tag;
            addr_err_q <= tag_q == TAG_ADDR && mismatch;
            data_err_q <= tag_q == TAG_DATA && mismatch;
            perr_hi_q  <= perr_drive;
            DPE_STS_O  <= err || (DPE_STS_O && !STS_CLR_I);
            SSE_STS_O  <= SERR_OE_O || (SSE_STS_O && !STS_CLR_I);
            PERR_CNT_O <= STS_CLR_I ? CNT_W'(err) :
                          (err && PERR_CNT_O != '1) ? PERR_CNT_O + CNT_W'(1) : PERR_CNT_O;
        end
    end
endmodule

// File: tb/tb_pci_parity_checker.sv
// tb_pci_parity_checker: directed and random stimulus checked against a cycle-history parity model
module tb_pci_parity_checker;
    localparam int N = 8192;
    logic        PHY_CLK33_I = 1'b0;
    logic        PHY_RSTn_I, PGEN_PAR_I, FRAMEn_I, IRDYn_I, TRDYn_I, TGT_WR_I;
    logic        PERR_EN_I, SERR_EN_I, STS_CLR_I;
    logic [31:0] PGEN_AD_I;
    logic [3:0]  PGEN_CBEn_I;
    logic        PERRn_O, PERR_OE_O, SERRn_O, SERR_OE_O, DPE_STS_O, SSE_STS_O;
    logic [7:0]  PERR_CNT_O;
    int checks = 0, errors = 0;

    pci_parity_checker #(.CNT_W(8)) dut (
        .PHY_CLK33_I (PHY_CLK33_I), .PHY_RSTn_I (PHY_RSTn_I),
        .PGEN_AD_I   (PGEN_AD_I),   .PGEN_CBEn_I (PGEN_CBEn_I), .PGEN_PAR_I (PGEN_PAR_I),
        .FRAMEn_I    (FRAMEn_I),    .IRDYn_I    (IRDYn_I),     .TRDYn_I    (TRDYn_I),
        .TGT_WR_I    (TGT_WR_I),    .PERR_EN_I  (PERR_EN_I),   .SERR_EN_I  (SERR_EN_I),
        .STS_CLR_I   (STS_CLR_I),   .PERRn_O    (PERRn_O),     .PERR_OE_O  (PERR_OE_O),
        .SERRn_O     (SERRn_O),     .SERR_OE_O  (SERR_OE_O),   .DPE_STS_O  (DPE_STS_O),
        .SSE_STS_O   (SSE_STS_O),   .PERR_CNT_O (PERR_CNT_O)
    );

    always #5 PHY_CLK33_I = ~PHY_CLK33_I;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle history of sampled inputs; expected outputs are derived from the phase two cycles back
    logic       fr_a[N], irdy_a[N], trdy_a[N], wr_a[N], r_a[N], pen_a[N], sen_a[N], clr_a[N], par_a[N];
    logic [31:0] ad_a[N];
    logic [3:0]  cbe_a[N];
    int         tag_a[N];
    logic       aerr_a[N], derr_a[N], drv_a[N], serr_a[N];
    int t = 0, m_cnt = 0;
    logic m_dpe = 0, m_sse = 0;

    always @(negedge PHY_CLK33_I) begin
        logic prev, dacb, addr, e, calc;
        if (t < N) begin
            fr_a[t] = FRAMEn_I; irdy_a[t] = IRDYn_I; trdy_a[t] = TRDYn_I; wr_a[t] = TGT_WR_I;
            r_a[t] = !PHY_RSTn_I; pen_a[t] = PERR_EN_I; sen_a[t] = SERR_EN_I; clr_a[t] = STS_CLR_I;
            par_a[t] = PGEN_PAR_I; ad_a[t] = PGEN_AD_I; cbe_a[t] = PGEN_CBEn_I;
            prev = t > 0 && !r_a[t-1];
            dacb = prev && tag_a[t-1] == 1 && cbe_a[t-1] == 4'hD;
            addr = !fr_a[t] && (!prev || fr_a[t-1]);
            tag_a[t] = dacb ? 0 : addr ? 1 : (!irdy_a[t] && !trdy_a[t] && wr_a[t]) ? 2 : 0;
            aerr_a[t] = 1'b0;
            derr_a[t] = 1'b0;
            if (t >= 2 && !r_a[t-2] && !r_a[t-1] && tag_a[t-2] != 0) begin
                calc = ($countones({ad_a[t-2], cbe_a[t-2]}) % 2) == 1;
                if (par_a[t-1] != calc) begin
                    aerr_a[t] = tag_a[t-2] == 1;
                    derr_a[t] = tag_a[t-2] == 2;
                end
            end
            drv_a[t] = derr_a[t] && pen_a[t];
            serr_a[t] = aerr_a[t] && pen_a[t] && sen_a[t];
            if (t == 0 || r_a[t-1]) begin
                m_dpe = 0; m_sse = 0; m_cnt = 0;
            end else begin
                e = aerr_a[t-1] || derr_a[t-1];
                m_dpe = e || (m_dpe && !clr_a[t-1]);
                m_sse = serr_a[t-1] || (m_sse && !clr_a[t-1]);
                m_cnt = clr_a[t-1] ? int'(e) : (e && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            end
            if (t >= 1) begin
                chk("perrn", PERRn_O, !drv_a[t]);
                chk("perr_oe", PERR_OE_O, drv_a[t] || (drv_a[t-1] && !r_a[t-1]));
                chk("serr_oe", SERR_OE_O, serr_a[t]);
                chk("serrn", SERRn_O, !serr_a[t]);
                chk("dpe", DPE_STS_O, m_dpe);
                chk("sse", SSE_STS_O, m_sse);
                chk("cnt", PERR_CNT_O, m_cnt);
            end
            t++;
        end
    end

    task automatic idle();
        PHY_RSTn_I = 1; FRAMEn_I = 1; IRDYn_I = 1; TRDYn_I = 1; TGT_WR_I = 0;
        PERR_EN_I = 1; SERR_EN_I = 1; STS_CLR_I = 0;
        PGEN_AD_I = '0; PGEN_CBEn_I = '0; PGEN_PAR_I = 0;
    endtask

    task automatic nxt();
        @(posedge PHY_CLK33_I);
        #1;
        idle();
    endtask

    task automatic data_phase();
        IRDYn_I = 0; TRDYn_I = 0; TGT_WR_I = 1;
        PGEN_AD_I = 32'hFFFF_FFFF; PGEN_CBEn_I = 4'h0;
    endtask

    task automatic clear_sts();
        nxt(); STS_CLR_I = 1;
        nxt();
    endtask

    initial begin
        logic held;
        idle();
        PHY_RSTn_I = 0;
        repeat (3) begin nxt(); PHY_RSTn_I = 0; end
        nxt();
        @(negedge PHY_CLK33_I);
        chk("rst_perr_oe", PERR_OE_O, 0);
        chk("rst_serrn", SERRn_O, 1);
        chk("rst_cnt", PERR_CNT_O, 0);
        // address phase with correct parity
        nxt(); FRAMEn_I = 0; PGEN_AD_I = 32'h1; PGEN_CBEn_I = 4'h6;
        nxt(); PGEN_PAR_I = 1;
        nxt(); @(negedge PHY_CLK33_I);
        chk("addr_ok_serr_oe", SERR_OE_O, 0);
        nxt(); @(negedge PHY_CLK33_I);
        chk("addr_ok_dpe", DPE_STS_O, 0);
        chk("addr_ok_cnt", PERR_CNT_O, 0);
        // same address phase with bad parity
        nxt(); FRAMEn_I = 0; PGEN_AD_I = 32'h1; PGEN_CBEn_I = 4'h6;
        nxt(); PGEN_PAR_I = 0;
        nxt(); @(negedge PHY_CLK33_I);
        chk("addr_bad_serr_oe", SERR_OE_O, 1);
        chk("addr_bad_serrn", SERRn_O, 0);
        nxt(); @(negedge PHY_CLK33_I);
        chk("addr_bad_serr_oe_off", SERR_OE_O, 0);
        chk("addr_bad_dpe", DPE_STS_O, 1);
        chk("addr_bad_sse", SSE_STS_O, 1);
        chk("addr_bad_cnt", PERR_CNT_O, 1);
        clear_sts();
        // write data phase with bad parity
        nxt(); data_phase();
        nxt(); PGEN_PAR_I = 1;
        nxt(); @(negedge PHY_CLK33_I);
        chk("data_n2_perrn", PERRn_O, 0);
        chk("data_n2_oe", PERR_OE_O, 1);
        nxt(); @(negedge PHY_CLK33_I);
        chk("data_n3_perrn", PERRn_O, 1);
        chk("data_n3_oe", PERR_OE_O, 1);
        chk("data_n3_cnt", PERR_CNT_O, 1);
        nxt(); @(negedge PHY_CLK33_I);
        chk("data_n4_oe", PERR_OE_O, 0);
        clear_sts();
        // same error with PERR# disabled
        nxt(); data_phase(); PERR_EN_I = 0;
        nxt(); PGEN_PAR_I = 1; PERR_EN_I = 0;
        nxt(); PERR_EN_I = 0; @(negedge PHY_CLK33_I);
        chk("dis_oe", PERR_OE_O, 0);
        nxt(); PERR_EN_I = 0; @(negedge PHY_CLK33_I);
        chk("dis_oe_n3", PERR_OE_O, 0);
        chk("dis_dpe", DPE_STS_O, 1);
        chk("dis_cnt", PERR_CNT_O, 1);
        clear_sts();
        // 300 back-to-back erroring phases, then clear colliding with the last error
        held = 1;
        for (int i = 0; i < 300; i++) begin
            nxt(); data_phase(); PGEN_PAR_I = 1;
            @(negedge PHY_CLK33_I);
            if (i >= 2) held &= PERR_OE_O & ~PERRn_O;
        end
        nxt(); PGEN_PAR_I = 1; @(negedge PHY_CLK33_I);
        held &= PERR_OE_O & ~PERRn_O;
        nxt(); STS_CLR_I = 1; @(negedge PHY_CLK33_I);
        held &= PERR_OE_O & ~PERRn_O;
        chk("sat_cnt", PERR_CNT_O, 255);
        nxt(); @(negedge PHY_CLK33_I);
        chk("sat_held", held, 1);
        chk("clr_win_cnt", PERR_CNT_O, 1);
        chk("clr_win_dpe", DPE_STS_O, 1);
        chk("sat_drive_high", PERRn_O, 1);
        // reset while an error is in flight
        nxt(); data_phase();
        nxt(); PGEN_PAR_I = 1; PHY_RSTn_I = 0;
        nxt(); @(negedge PHY_CLK33_I);
        chk("rst_mid_perr_oe", PERR_OE_O, 0);
        chk("rst_mid_serr_oe", SERR_OE_O, 0);
        nxt(); @(negedge PHY_CLK33_I);
        chk("rst_mid_dpe", DPE_STS_O, 0);
        chk("rst_mid_sse", SSE_STS_O, 0);
        chk("rst_mid_cnt", PERR_CNT_O, 0);
        // random traffic, including DAC commands, clears and resets
        for (int i = 0; i < 3000; i++) begin
            nxt();
            PHY_RSTn_I  = $urandom_range(199) != 0;
            FRAMEn_I    = $urandom_range(3) != 0;
            IRDYn_I     = 1'($urandom);
            TRDYn_I     = 1'($urandom);
            TGT_WR_I    = 1'($urandom);
            PERR_EN_I   = $urandom_range(7) != 0;
            SERR_EN_I   = $urandom_range(7) != 0;
            STS_CLR_I   = $urandom_range(15) == 0;
            PGEN_AD_I   = $urandom;
            PGEN_CBEn_I = $urandom_range(3) == 0 ? 4'hD : 4'($urandom);
            PGEN_PAR_I  = 1'($urandom);
        end
        nxt(); nxt(); nxt();
        @(negedge PHY_CLK33_I);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
